cpu6502_bus_ctrl: RTL

Memory-bus controller between the PIF 6502 core and its memories. It decodes each CPU access into the 4 KB boot ROM, the 16 KB work RAM or the external I/O window, and drives the one-cycle-latency ROM/RAM strobe handshakes. It returns read data to the CPU with a one-cycle `cpu_done` pulse and stalls the CPU until then. It sits directly upstream of the boot ROM and consumes its `q_a`/`valid`.

---
 rtl/pif6502_pkg.sv | 25 ++
 rtl/cpu6502_addr_decode.sv | 27 ++
 rtl/cpu6502_bus_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pif6502_pkg.sv
// Shared definitions for the PIF 6502 memory-bus controller: address map,
// controller states and decoded access regions.
package pif6502_pkg;

  localparam logic [15:0] RAM_BASE = 16'h0000;
  localparam logic [15:0] RAM_TOP  = 16'h3FFF;
  localparam logic [15:0] IO_BASE  = 16'h4000;
  localparam logic [15:0] IO_TOP   = 16'hBFFF;
  localparam logic [15:0] ROM_BASE = 16'hC000;
  localparam logic [11:0] ROM_MASK = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE,
    ROM_WAIT,
    RAM_WAIT,
    IO_WAIT
  } state_t;

  typedef enum logic [1:0] {
    RAM,
    IO,
    ROM
  } region_t;

endpackage

// File: rtl/cpu6502_addr_decode.sv
// Combinational decode of a CPU byte address into its target region and the
// region-local address. ROM space is mirrored every 4 KB.
module cpu6502_addr_decode
  import pif6502_pkg::*;
(
  input  logic [15:0] cpu_addr_i,
  output region_t     region_o,
  output logic [11:0] rom_addr_o,
  output logic [13:0] ram_addr_o,
  output logic [14:0] io_addr_o
);

  // Region select plus local address for every target.
  always_comb begin
    rom_addr_o = cpu_addr_i[11:0] & ROM_MASK;
    ram_addr_o = 14'(cpu_addr_i - RAM_BASE);
    io_addr_o  = cpu_addr_i[14:0];
    if (cpu_addr_i >= ROM_BASE) begin
      region_o = ROM;
    end else if (cpu_addr_i >= IO_BASE) begin
      region_o = IO;
    end else begin
      region_o = RAM;
    end
  end

endmodule

// File: rtl/cpu6502_bus_ctrl.sv
// Memory-bus controller between the 6502 core and boot ROM, work RAM and the
// external I/O window. One access in flight at a time; the CPU is stalled
// until a single-cycle cpu_done pulse returns the read data.
module cpu6502_bus_ctrl
  import pif6502_pkg::*;
#(
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        cpu_done,
  output logic [11:0] rom_address,
  output logic        rom_oe,
  input  logic        rom_valid,
  input  logic [7:0]  rom_q,
  output logic [13:0] ram_address,
  output logic        ram_oe,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic        ram_valid,
  input  logic [7:0]  ram_q,
  output logic [14:0] io_addr,
  output logic        io_rd,
  output logic        io_wr,
  output logic [7:0]  io_wdata,
  input  logic        io_ack,
  input  logic [7:0]  io_rdata,
  output logic        err_rom_write,
  output logic        err_io_timeout
);

  localparam int unsigned      CNT_W    = $clog2(IO_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

  state_t           state_q;
  logic             we_q;
  logic [7:0]       cpu_din_q;
  logic             cpu_done_q;
  logic [11:0]      rom_address_q;
  logic             rom_oe_q;
  logic [13:0]      ram_address_q;
  logic             ram_oe_q;
  logic             ram_we_q;
  logic [7:0]       ram_wdata_q;
  logic [14:0]      io_addr_q;
  logic             io_rd_q;
  logic             io_wr_q;
  logic [7:0]       io_wdata_q;
  logic [CNT_W-1:0] io_cnt_q;
  logic             err_rom_write_q;
  logic             err_io_timeout_q;

  region_t          dec_region;
  logic [11:0]      dec_rom_addr;
  logic [13:0]      dec_ram_addr;
  logic [14:0]      dec_io_addr;

  cpu6502_addr_decode u_decode (
    .cpu_addr_i (cpu_addr),
    .region_o   (dec_region),
    .rom_addr_o (dec_rom_addr),
    .ram_addr_o (dec_ram_addr),
    .io_addr_o  (dec_io_addr)
  );

  // Access sequencer: accept, strobe the target, wait for its response, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      we_q             <= 1'b0;
      cpu_din_q        <= '0;
      cpu_done_q       <= 1'b0;
      rom_address_q    <= '0;
      rom_oe_q         <= 1'b0;
      ram_address_q    <= '0;
      ram_oe_q         <= 1'b0;
      ram_we_q         <= 1'b0;
      ram_wdata_q      <= '0;
      io_addr_q        <= '0;
      io_rd_q          <= 1'b0;
      io_wr_q          <= 1'b0;
      io_wdata_q       <= '0;
      io_cnt_q         <= '0;
      err_rom_write_q  <= 1'b0;
      err_io_timeout_q <= 1'b0;
    end else begin
      cpu_done_q <= 1'b0;
      rom_oe_q   <= 1'b0;
      ram_oe_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // The CPU still holds cpu_req while done is high; skipping that
          // cycle keeps a completed request from being issued twice.
          if (cpu_req && !cpu_done_q) begin
            we_q <= cpu_we;
            case (dec_region)
              ROM: begin
                rom_address_q <= dec_rom_addr;
                if (cpu_we) begin
                  err_rom_write_q <= 1'b1;
                end else begin
                  rom_oe_q <= 1'b1;
                end
                state_q <= ROM_WAIT;
              end
              RAM: begin
                ram_address_q <= dec_ram_addr;
                if (cpu_we) begin
                  ram_we_q    <= 1'b1;
                  ram_wdata_q <= cpu_dout;
                end else begin
                  ram_oe_q <= 1'b1;
                end
                state_q <= RAM_WAIT;
              end
              IO: begin
                io_addr_q <= dec_io_addr;
                io_rd_q   <= !cpu_we;
                io_wr_q   <= cpu_we;
                if (cpu_we) begin
                  io_wdata_q <= cpu_dout;
                end
                io_cnt_q <= '0;
                state_q  <= IO_WAIT;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        ROM_WAIT: begin
          if (we_q) begin
            cpu_done_q <= 1'b1;
            state_q    <= IDLE;
          end else if (rom_valid) begin
            cpu_din_q  <= rom_q;
            cpu_done_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        RAM_WAIT: begin
          if (we_q) begin
            cpu_done_q <= 1'b1;
            state_q    <= IDLE;
          end else if (ram_valid) begin
            cpu_din_q  <= ram_q;
            cpu_done_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        IO_WAIT: begin
          if (io_ack) begin
            if (!we_q) begin
              cpu_din_q <= io_rdata;
            end
            cpu_done_q <= 1'b1;
            io_rd_q    <= 1'b0;
            io_wr_q    <= 1'b0;
            state_q    <= IDLE;
          end else if (io_cnt_q == CNT_LAST) begin
            cpu_din_q        <= 8'hFF;
            err_io_timeout_q <= 1'b1;
            cpu_done_q       <= 1'b1;
            io_rd_q          <= 1'b0;
            io_wr_q          <= 1'b0;
            state_q          <= IDLE;
          end else begin
            io_cnt_q <= io_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_din        = cpu_din_q;
  assign cpu_done       = cpu_done_q;
  assign rom_address    = rom_address_q;
  assign rom_oe         = rom_oe_q;
  assign ram_address    = ram_address_q;
  assign ram_oe         = ram_oe_q;
  assign ram_we         = ram_we_q;
  assign ram_wdata      = ram_wdata_q;
  assign io_addr        = io_addr_q;
  assign io_rd          = io_rd_q;
  assign io_wr          = io_wr_q;
  assign io_wdata       = io_wdata_q;
  assign err_rom_write  = err_rom_write_q;
  assign err_io_timeout = err_io_timeout_q;

endmodule
